glyph_fetch: RTL and testbench
==============================

// Module: glyph_fetch
// PURPOSE
//   Pixel stage between VGAControl and the VGA pins. Maps each (hCount, vCount) to a 16x16-pixel tile
//   on a 40x30 grid and reads the tile byte from tile RAM. It then reads the 16-bit glyph row from
//   glyph ROM and emits the 3-3-2 RGB pixel.
//   hSync, vSync and bright are delayed to stay aligned with the rgb output. This stage replaces the
//   test-bar BitGen path for the snake game display.
// PARAMETERS
//   COLS       40   tiles per row; 640 / 16
//   ROWS       30   tile rows; 480 / 16
//   TILE_LOG2  4    log2 of tile edge in pixels
//   HVID       640  active pixels per line
//   VVID       480  active lines per frame
// PORTS
//   clk          in   1   25 MHz pixel clock
//   reset        in   1   synchronous, active-high
//   h_count      in   10  pixel column from VGAControl
//   v_count      in   10  line from VGAControl
//   h_sync_in    in   1   active-low hsync from VGAControl
//   v_sync_in    in   1   active-low vsync from VGAControl
//   bright_in    in   1   active-area flag from VGAControl
//   tile_addr    out  11  tile RAM read address; synchronous RAM with 1-cycle latency
//   tile_data    in   8   tile byte: [4:0] glyph id, [7:5] palette index
//   glyph_addr   out  9   glyph ROM address {glyph_id, row[3:0]}; synchronous ROM with 1-cycle latency
//   glyph_row    in   16  glyph row bits; bit 15 is the leftmost pixel
//   h_sync       out  1   h_sync_in delayed 3 cycles
//   v_sync       out  1   v_sync_in delayed 3 cycles
//   bright       out  1   bright_in delayed 3 cycles
//   rgb          out  8   pixel colour, RRR_GGG_BB
// BEHAVIOUR
//   - One clock and one reset. Reset is synchronous and active-high. All registers update on posedge clk.
//   - Reset values: h_sync=1, v_sync=1, bright=0, rgb=0, tile_addr=0, glyph_addr=0. All pipeline regs are 0.
//   - Fixed latency of 3 clocks from an input pixel to its rgb / h_sync / v_sync / bright.
//   - S0 (cycle n):
//     - tile_addr <= (v_count>>4)*40 + (h_count>>4), computed as (r<<5)+(r<<3)+c; no multiplier.
//     - Latch h_count[3:0], v_count[3:0] and the 3 sync/bright bits.
//   - S1 (n+1):
//     - glyph_addr <= {tile_data[4:0], v_lo}.
//     - Latch pal = tile_data[7:5] and h_lo.
//   - S2 (n+2), output valid at n+3:
//     - bit = glyph_row[15 - h_lo].
//     - rgb <= (bright_d2 & bit) ? PALETTE[pal] : BLACK.
//   - Off-screen inputs (h_count >= HVID or v_count >= VVID): tile_addr <= 0, and the pixel is forced to
//     BLACK regardless of bright_in. The tile address is always <= 1199.
//   - Palette index 0 is BLACK, so a foreground pixel of palette 0 is invisible. Glyph id 0 is blank by
//     ROM convention; this stage applies no special handling.
//   - Wrap-around needs no state: each pixel is handled independently, so line and frame boundaries
//     follow h_count / v_count directly.
//   - Reset mid-frame: outputs return to reset values on the next edge and hold while reset=1.
//     - The first post-reset pixel appears 3 cycles after reset falls.
//     - No partial pipeline contents survive reset.
//   - Pixels not on a tile boundary still issue reads every cycle. Tile RAM and glyph ROM must be
//     read-only from this port and never stall; there is no handshake.
// STRUCTURE
//   - vga_defs.vh holds the colour constants (BLACK, BLUE, GREEN, CYAN, RED, MAGENTA, YELLOW, WHITE),
//     the PALETTE[0..7] table in that order, the tile-byte field positions, and HVID/VVID.
//   - Sub-module sync_delay #(W=3, D=3): a shift register with reset value 3'b110 carrying
//     {h_sync, v_sync, bright}. It is shared with any future pipelined pixel stage.
//   - The address arithmetic and colour select stay inline.
// TESTING
//   - Reset: hold reset 5 cycles with random inputs -> h_sync=v_sync=1, bright=0, rgb=0 throughout.
//   - Address: h=17, v=33 -> tile_addr=81 at n+1. h=639, v=479 -> 1199. h=700, v=10 -> 0.
//   - Pixel: tile_data=8'b010_00011 and glyph_row=16'h8001 at the proper cycles.
//     - h_lo=0 -> rgb=GREEN at n+3.
//     - h_lo=1 -> BLACK.
//     - h_lo=15 -> GREEN.
//   - Alignment: drive a full frame from VGAControl with a behavioural RAM/ROM model -> h_sync, v_sync
//     and bright equal the inputs delayed exactly 3 cycles; rgb=0 whenever bright=0.
//   - Off-screen: bright_in forced 1 with h=650 and glyph_row=16'hFFFF, palette 7 -> rgb=BLACK.
//   - Reset mid-line: assert reset at h=300 for 1 cycle -> outputs at reset values.
//     - rgb follows the reference model from 3 cycles after release.
//     - No stale pixel from before reset appears.

Source files
------------

// File: rtl/glyph_fetch_pkg.sv
// glyph_fetch_pkg
//   Shared display definitions for the tile/glyph pixel path: screen geometry,
//   tile-byte field positions, the 3-3-2 colour constants, the 8-entry palette
//   and the shift-add tile index helper.
//   No ports (package).
package glyph_fetch_pkg;

  // Screen and tile geometry
  localparam int COLS      = 40;
  localparam int ROWS      = 30;
  localparam int TILE_LOG2 = 4;
  localparam logic [9:0] HVID = 10'd640;
  localparam logic [9:0] VVID = 10'd480;

  // Tile byte layout: [4:0] glyph id, [7:5] palette index
  localparam int GLYPH_LSB = 0;
  localparam int GLYPH_MSB = 4;
  localparam int PAL_LSB   = 5;
  localparam int PAL_MSB   = 7;

  // Reset pattern of the {h_sync, v_sync, bright} delay line (syncs idle high)
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  // Colours, RRR_GGG_BB
  localparam logic [7:0] BLACK   = 8'b000_000_00;
  localparam logic [7:0] BLUE    = 8'b000_000_11;
  localparam logic [7:0] GREEN   = 8'b000_111_00;
  localparam logic [7:0] CYAN    = 8'b000_111_11;
  localparam logic [7:0] RED     = 8'b111_000_00;
  localparam logic [7:0] MAGENTA = 8'b111_000_11;
  localparam logic [7:0] YELLOW  = 8'b111_111_00;
  localparam logic [7:0] WHITE   = 8'b111_111_11;

  // Palette lookup; index 0 is black so palette-0 foreground is invisible
  function automatic logic [7:0] paletteColor(input logic [2:0] idx);
    logic [7:0] col;
    case (idx)
      3'd0:    col = BLACK;
      3'd1:    col = BLUE;
      3'd2:    col = GREEN;
      3'd3:    col = CYAN;
      3'd4:    col = RED;
      3'd5:    col = MAGENTA;
      3'd6:    col = YELLOW;
      3'd7:    col = WHITE;
      default: col = BLACK;
    endcase
    return col;
  endfunction

  // row*40 + col as (row<<5)+(row<<3)+col, so no multiplier is inferred
  function automatic logic [10:0] tileIndex(input logic [5:0] row, input logic [5:0] col);
    logic [10:0] rowW;
    logic [10:0] colW;
    rowW = {5'd0, row};
    colW = {5'd0, col};
    return (rowW << 5) + (rowW << 3) + colW;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// sync_delay
//   Fixed-depth shift register used to keep sync/blank flags aligned with a
//   pipelined pixel stage. Every stage loads RESET_VAL on reset so no stale
//   flags survive a reset.
//   Ports:
//     clk   in  1   clock
//     reset in  1   synchronous, active-high
//     din   in  W   flags entering the pipeline
//     dout  out W   flags delayed by D clocks (registered)
module sync_delay #(
  parameter int         W         = 3,
  parameter int         D         = 3,
  parameter logic [W-1:0] RESET_VAL = 3'b110
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipeR [D];

  // Shift the flags one stage per clock, flushing all stages on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < D; i++) begin
        pipeR[i] <= RESET_VAL;
      end
    end else begin
      pipeR[0] <= din;
      for (int i = 1; i < D; i++) begin
        pipeR[i] <= pipeR[i-1];
      end
    end
  end

  assign dout = pipeR[D-1];

endmodule

// File: rtl/glyph_fetch.sv
// glyph_fetch
//   Pixel stage between the VGA timing generator and the pins. Each pixel is
//   mapped to a 16x16 tile of a 40x30 grid, the tile byte is read from tile RAM,
//   the glyph row from glyph ROM, and the 3-3-2 colour is emitted 3 clocks after
//   the pixel coordinates arrived. Sync and bright flags are delayed to match.
//   Ports:
//     clk        in  1   pixel clock
//     reset      in  1   synchronous, active-high
//     h_count    in  10  pixel column
//     v_count    in  10  line
//     h_sync_in  in  1   active-low hsync
//     v_sync_in  in  1   active-low vsync
//     bright_in  in  1   active-area flag
//     tile_addr  out 11  tile RAM read address
//     tile_data  in  8   tile byte {palette[2:0], glyph[4:0]}
//     glyph_addr out 9   glyph ROM address {glyph, row[3:0]}
//     glyph_row  in  16  glyph row, bit 15 leftmost
//     h_sync     out 1   h_sync_in delayed 3 clocks
//     v_sync     out 1   v_sync_in delayed 3 clocks
//     bright     out 1   bright_in delayed 3 clocks
//     rgb        out 8   pixel colour RRR_GGG_BB
module glyph_fetch
  import glyph_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic        bright_in,
  output logic [10:0] tile_addr,
  input  logic [7:0]  tile_data,
  output logic [8:0]  glyph_addr,
  input  logic [15:0] glyph_row,
  output logic        h_sync,
  output logic        v_sync,
  output logic        bright,
  output logic [7:0]  rgb
);

  // Stage 0 combinational terms
  logic        onScreenS;
  logic [10:0] tileAddrS;
  logic        visibleS;

  // Stage 0 registers
  logic [10:0] tileAddrR;
  logic [3:0]  hLo0R;
  logic [3:0]  vLo0R;
  logic        vis0R;

  // Stage 1 registers
  logic [8:0]  glyphAddrR;
  logic [2:0]  palR;
  logic [3:0]  hLo1R;
  logic        vis1R;

  // Stage 2 terms and output register
  logic        pixelBitS;
  logic [7:0]  rgbS;
  logic [7:0]  rgbR;

  logic [2:0]  syncOutS;

  // Tile address and visibility; off-screen pixels address tile 0 and are
  // never visible, which also keeps the address within the 1200-entry RAM
  always_comb begin
    onScreenS = 1'b0;
    tileAddrS = 11'd0;
    if ((h_count < HVID) && (v_count < VVID)) begin
      onScreenS = 1'b1;
      tileAddrS = tileIndex(v_count[9:TILE_LOG2], h_count[9:TILE_LOG2]);
    end else begin
      onScreenS = 1'b0;
      tileAddrS = 11'd0;
    end
    visibleS = bright_in & onScreenS;
  end

  // Stage 0: issue tile RAM read, latch in-tile pixel position
  always_ff @(posedge clk) begin
    if (reset) begin
      tileAddrR <= 11'd0;
      hLo0R     <= 4'd0;
      vLo0R     <= 4'd0;
      vis0R     <= 1'b0;
    end else begin
      tileAddrR <= tileAddrS;
      hLo0R     <= h_count[TILE_LOG2-1:0];
      vLo0R     <= v_count[TILE_LOG2-1:0];
      vis0R     <= visibleS;
    end
  end

  // Stage 1: issue glyph ROM read from the returned tile byte
  always_ff @(posedge clk) begin
    if (reset) begin
      glyphAddrR <= 9'd0;
      palR       <= 3'd0;
      hLo1R      <= 4'd0;
      vis1R      <= 1'b0;
    end else begin
      glyphAddrR <= {tile_data[GLYPH_MSB:GLYPH_LSB], vLo0R};
      palR       <= tile_data[PAL_MSB:PAL_LSB];
      hLo1R      <= hLo0R;
      vis1R      <= vis0R;
    end
  end

  // Pick the glyph bit for this column (bit 15 is leftmost) and colour it
  always_comb begin
    pixelBitS = glyph_row[4'd15 - hLo1R];
    rgbS      = BLACK;
    if (vis1R && pixelBitS) begin
      rgbS = paletteColor(palR);
    end else begin
      rgbS = BLACK;
    end
  end

  // Stage 2: register the output colour
  always_ff @(posedge clk) begin
    if (reset) begin
      rgbR <= BLACK;
    end else begin
      rgbR <= rgbS;
    end
  end

  sync_delay #(
    .W         (3),
    .D         (3),
    .RESET_VAL (SYNC_IDLE)
  ) syncDelay (
    .clk   (clk),
    .reset (reset),
    .din   ({h_sync_in, v_sync_in, bright_in}),
    .dout  (syncOutS)
  );

  assign tile_addr  = tileAddrR;
  assign glyph_addr = glyphAddrR;
  assign rgb        = rgbR;
  assign h_sync     = syncOutS[2];
  assign v_sync     = syncOutS[1];
  assign bright     = syncOutS[0];

endmodule

// File: tb/tb_glyph_fetch.sv
module tb_glyph_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        h_sync_in;
  logic        v_sync_in;
  logic        bright_in;
  logic [10:0] tile_addr;
  logic [7:0]  tile_data;
  logic [8:0]  glyph_addr;
  logic [15:0] glyph_row;
  logic        h_sync;
  logic        v_sync;
  logic        bright;
  logic [7:0]  rgb;

  int nChecks = 0;
  int nErrors = 0;

  // Behavioural memories behind the read ports
  logic [7:0]  ram [0:2047];
  logic [15:0] rom [0:511];

  assign tile_data = ram[tile_addr];
  assign glyph_row = rom[glyph_addr];

  always #20 clk = ~clk;

  glyph_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .h_count    (h_count),
    .v_count    (v_count),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .bright_in  (bright_in),
    .tile_addr  (tile_addr),
    .tile_data  (tile_data),
    .glyph_addr (glyph_addr),
    .glyph_row  (glyph_row),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .bright     (bright),
    .rgb        (rgb)
  );

  // Reference colours in palette order
  logic [7:0] palRef [0:7];
  initial begin
    palRef[0] = 8'h00; palRef[1] = 8'h03; palRef[2] = 8'h1C; palRef[3] = 8'h1F;
    palRef[4] = 8'hE0; palRef[5] = 8'hE3; palRef[6] = 8'hFC; palRef[7] = 8'hFF;
  end

  typedef struct {
    logic       hs;
    logic       vs;
    logic       br;
    logic [7:0] col;
  } outExp_t;

  outExp_t expQ[$];

  // Pixel colour straight from the display rules, using integer arithmetic
  function automatic outExp_t refPixel(input int h, input int v, input bit hs, input bit vs, input bit br);
    outExp_t e;
    int t;
    int g;
    e.hs  = hs;
    e.vs  = vs;
    e.br  = br;
    e.col = 8'h00;
    if (br && h < 640 && v < 480) begin
      t = int'(ram[(v / 16) * 40 + (h / 16)]);
      g = int'(rom[(t % 32) * 16 + (v % 16)]);
      if (((g >> (15 - (h % 16))) & 1) == 1) e.col = palRef[t / 32];
    end
    return e;
  endfunction

  function automatic outExp_t resetExp();
    outExp_t e;
    e.hs = 1'b1; e.vs = 1'b1; e.br = 1'b0; e.col = 8'h00;
    return e;
  endfunction

  // One pixel clock: check the output due now, then drive the next pixel
  task automatic step(input bit rst, input int h, input int v, input bit hs, input bit vs, input bit br);
    outExp_t e;
    int n;
    @(negedge clk);
    if (expQ.size() == 3) begin
      e = expQ.pop_front();
      nChecks++;
      if ({h_sync, v_sync, bright, rgb} !== {e.hs, e.vs, e.br, e.col}) begin
        nErrors++;
        $display("FAIL pipe t=%0t: got hs=%b vs=%b br=%b rgb=%h, want hs=%b vs=%b br=%b rgb=%h",
                 $time, h_sync, v_sync, bright, rgb, e.hs, e.vs, e.br, e.col);
      end
      if (bright === 1'b0) begin
        nChecks++;
        if (rgb !== 8'h00) begin
          nErrors++;
          $display("FAIL blank t=%0t: got rgb=%h while bright=0, want 00", $time, rgb);
        end
      end
    end
    reset     = rst;
    h_count   = 10'(h);
    v_count   = 10'(v);
    h_sync_in = hs;
    v_sync_in = vs;
    bright_in = br;
    if (rst) begin
      // Reset flushes everything in flight
      n = expQ.size();
      expQ.delete();
      for (int i = 0; i < n; i++) expQ.push_back(resetExp());
      expQ.push_back(resetExp());
    end else begin
      expQ.push_back(refPixel(h, v, hs, vs, br));
    end
  endtask

  // Drive one scan line with VGA-like sync timing
  task automatic scanLine(input int v, input int rstAt);
    bit hs;
    bit vs;
    bit br;
    for (int hc = 0; hc < 800; hc++) begin
      hs = !(hc >= 656 && hc < 752);
      vs = !(v >= 490 && v < 492);
      br = (hc < 640 && v < 480);
      if ($urandom_range(15, 0) == 0) br = ~br;
      step(hc == rstAt, hc, v, hs, vs, br);
    end
  endtask

  typedef struct {
    logic [7:0]  ramFill;
    logic [15:0] romFill;
    int          h;
    int          v;
    logic        br;
    logic [10:0] expAddr;
    logic [8:0]  expGlyph;
    logic [7:0]  expRgb;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset     = 1'b1;
    h_count   = 10'd0;
    v_count   = 10'd0;
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    bright_in = 1'b0;
    for (int i = 0; i < 2048; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 512; i++)  rom[i] = 16'($urandom);

    // Reset held 5 cycles with random inputs
    for (int i = 0; i < 5; i++) begin
      step(1'b1, int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)),
           1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Lines across the frame including the last active line and blanking
    scanLine(5, -1);
    scanLine(479, -1);
    scanLine(int'($urandom_range(524, 0)), -1);
    scanLine(491, -1);
    scanLine(130, -1);

    // Single-cycle reset in the middle of a line
    scanLine(200, 300);
    scanLine(201, -1);

    // Flush the last in-flight pixels
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0);

    // Directed vectors with uniform memory contents
    vecs.push_back('{8'b010_00011, 16'h8001, 17,  33,  1'b1, 11'd81,   9'd49, 8'h00});
    vecs.push_back('{8'b010_00011, 16'h8001, 639, 479, 1'b1, 11'd1199, 9'd63, 8'h1C});
    vecs.push_back('{8'b010_00011, 16'h8001, 700, 10,  1'b1, 11'd0,    9'd58, 8'h00});
    vecs.push_back('{8'b010_00011, 16'h8001, 0,   0,   1'b1, 11'd0,    9'd48, 8'h1C});
    vecs.push_back('{8'b010_00011, 16'h8001, 1,   0,   1'b1, 11'd0,    9'd48, 8'h00});
    vecs.push_back('{8'b010_00011, 16'h8001, 15,  0,   1'b1, 11'd0,    9'd48, 8'h1C});
    vecs.push_back('{8'b010_00011, 16'h8001, 32,  5,   1'b1, 11'd2,    9'd53, 8'h1C});
    vecs.push_back('{8'b010_00011, 16'h8001, 16,  16,  1'b0, 11'd41,   9'd48, 8'h00});
    vecs.push_back('{8'b010_00011, 16'h8001, 100, 479, 1'b1, 11'd1166, 9'd63, 8'h00});
    vecs.push_back('{8'b111_00001, 16'hFFFF, 650, 100, 1'b1, 11'd0,    9'd20, 8'h00});
    vecs.push_back('{8'b111_00001, 16'hFFFF, 100, 100, 1'b1, 11'd246,  9'd20, 8'hFF});
    vecs.push_back('{8'b000_00001, 16'hFFFF, 100, 100, 1'b1, 11'd246,  9'd20, 8'h00});

    for (int k = 0; k < vecs.size(); k++) begin
      for (int i = 0; i < 2048; i++) ram[i] = vecs[k].ramFill;
      for (int i = 0; i < 512; i++)  rom[i] = vecs[k].romFill;
      @(negedge clk);
      reset     = 1'b0;
      h_count   = 10'(vecs[k].h);
      v_count   = 10'(vecs[k].v);
      h_sync_in = 1'b1;
      v_sync_in = 1'b1;
      bright_in = vecs[k].br;
      @(negedge clk);
      nChecks++;
      if (tile_addr !== vecs[k].expAddr) begin
        nErrors++;
        $display("FAIL vec%0d tile_addr: got %0d want %0d", k, tile_addr, vecs[k].expAddr);
      end
      @(negedge clk);
      nChecks++;
      if (glyph_addr !== vecs[k].expGlyph) begin
        nErrors++;
        $display("FAIL vec%0d glyph_addr: got %0d want %0d", k, glyph_addr, vecs[k].expGlyph);
      end
      @(negedge clk);
      nChecks++;
      if (rgb !== vecs[k].expRgb) begin
        nErrors++;
        $display("FAIL vec%0d rgb: got %h want %h", k, rgb, vecs[k].expRgb);
      end
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
